// File: rtl/rr_bus_mux_pkg.sv
// Constants shared by the bus-family blocks: packet state encodings and
// the supported channel-count limits.
package rr_bus_mux_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } bus_state_e;

   localparam int BUS_MIN_N = 2;
   localparam int BUS_MAX_N = 32;

endpackage

// File: rtl/rr_bus_mux_pick.sv
// Combinational round-robin search: first asserted req at ptr, ptr+1, ...
// wrapping modulo N (N is a power of two, so the SEL_W-bit add wraps).
module rr_priority_pick #(
   parameter int N     = 8,
   parameter int SEL_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_id,
   output logic             gnt_vld
);

   logic [SEL_W-1:0] idx;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = ptr;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = ptr + SEL_W'(k);
         if (!gnt_vld && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx;
         end
      end
   end

endmodule

// File: rtl/rr_bus_mux.sv
// N-channel packet mux into a single registered output beat, with
// round-robin or legacy sel-driven arbitration and per-packet locking.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  ST_IDLE   | no packet open; arbitrate (round-robin or manual sel)
//  ST_LOCKED | packet open on grant_id; only that channel is served
module rr_bus_mux #(
   parameter int WIDTH = 32,
   parameter int N     = 8,
   parameter int SEL_W = 3
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   input  logic [N-1:0]       in_last,
   output logic [N-1:0]       in_ready,
   input  logic               manual,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   output logic               out_last,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   grant_id
);

   import rr_bus_mux_pkg::*;

   bus_state_e       state_q, state_d;
   logic [SEL_W-1:0] ptr_q;
   logic [SEL_W-1:0] pick_id;
   logic             pick_vld;
   logic [SEL_W-1:0] cur_id;
   logic             cur_en;
   logic             can_load;
   logic             accept;
   logic [N-1:0]     ready_vec;
   logic [WIDTH-1:0] cur_data;
   logic             cur_last;

   rr_priority_pick #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_pick (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_id  (pick_id),
      .gnt_vld (pick_vld)
   );

   // Current grant target: manual/sel are only looked at while idle.
   always_comb begin
      cur_id = grant_id;
      cur_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (manual) begin
               cur_id = sel;
               cur_en = in_valid[sel];
            end else begin
               cur_id = pick_id;
               cur_en = pick_vld;
            end
         end
         ST_LOCKED: begin
            cur_id = grant_id;
            cur_en = 1'b1;
         end
         default: begin
            cur_id = grant_id;
            cur_en = 1'b0;
         end
      endcase
   end

   assign can_load = !out_valid || out_ready;

   always_comb begin
      ready_vec = '0;
      cur_data  = '0;
      cur_last  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (cur_id == SEL_W'(i)) begin
            ready_vec[i] = reset_n && can_load && cur_en;
            cur_data     = in_data[i*WIDTH +: WIDTH];
            cur_last     = in_last[i];
         end
      end
   end

   assign in_ready = ready_vec;
   assign accept   = |(ready_vec & in_valid);

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = cur_last ? ST_IDLE : ST_LOCKED;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         grant_id  <= '0;
         ptr_q     <= '0;
      end else if (accept) begin
         out_data  <= cur_data;
         out_valid <= 1'b1;
         out_last  <= cur_last;
         grant_id  <= cur_id;
         if (cur_last) begin
            ptr_q <= cur_id + SEL_W'(1);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/rr_bus_mux.md
RR_BUS_MUX -- requirements
Module: rr_bus_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width per channel, >=1.
REQ-002 Parameter N, default 8: channel count, power of two, 2..32.
REQ-003 Parameter SEL_W, default 3: equals log2(N).
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 in_data  in  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  in  N  per-channel beat valid.
REQ-008 in_last  in  N  per-channel last beat of packet.
REQ-009 in_ready  out  N  per-channel beat accepted when valid & ready.
REQ-010 manual  in  1  1 = legacy select mode, channel chosen by sel; 0 = round-robin arbitration.
REQ-011 sel  in  SEL_W  channel index used when manual=1.
REQ-012 out_data  out  WIDTH  registered output beat.
REQ-013 out_valid  out  1  out_data holds an unconsumed beat.
REQ-014 out_last  out  1  registered copy of accepted in_last.
REQ-015 out_ready  in  1  downstream accepts when out_valid & out_ready.
REQ-016 grant_id  out  SEL_W  channel currently or most recently granted.

Function
REQ-017 Output stage SHALL be one register; can_load = !out_valid | out_ready.
REQ-018 At most one in_ready bit SHALL be high per cycle; in_ready[g] = can_load & (g is current grant) & state allows.
REQ-019 Accepted beat SHALL appear on out_data/out_last with out_valid=1 the following cycle (latency 1); full throughput 1 beat/cycle when out_ready held high.
REQ-020 out_valid SHALL clear after a cycle with out_valid & out_ready & no new accept.
REQ-021 out_data/out_last SHALL hold stable while out_valid & !out_ready.
REQ-022 State machine SHALL have two states: IDLE (no packet open), LOCKED (packet open on grant_id).
REQ-023 In IDLE, manual=0: eligible channel SHALL be first i with in_valid[i] searching ptr, ptr+1, ... wrapping modulo N; ptr resets to 0.
REQ-024 In IDLE, manual=1: eligible channel SHALL be sel only if in_valid[sel], else none.
REQ-025 In IDLE, eligible channel SHALL be granted combinationally and its first beat accepted same cycle if can_load.
REQ-026 IDLE->LOCKED when an accepted beat has in_last=0; grant_id registers that channel.
REQ-027 In LOCKED, only grant_id SHALL be served; manual, sel and other in_valid ignored.
REQ-028 On accepted beat with in_last=1 (either state): state->IDLE, ptr<=grant+1 mod N; ptr SHALL update in manual mode too.
REQ-029 No eligible channel or !can_load: no accept, state and ptr unchanged.
REQ-030 grant_id SHALL update on every accept and hold otherwise.
REQ-031 Changes to manual/sel SHALL take effect only at next IDLE arbitration.

Reset
REQ-032 While reset_n=0 at a rising edge: out_valid=0, out_last=0, out_data=0, grant_id=0, ptr=0, state=IDLE.
REQ-033 in_ready SHALL be all-zero in any cycle where reset_n=0.
REQ-034 Reset mid-packet SHALL discard the open packet and the held output beat; no partial resume.

Structure
REQ-035 State encodings (IDLE=0, LOCKED=1) SHALL live in a shared constants include used by all bus-family blocks.
REQ-036 Round-robin search SHALL be a sub-module rr_priority_pick (req N, ptr SEL_W -> gnt_id SEL_W, gnt_vld 1), purely combinational.
REQ-037 No tristate drivers internally; selection SHALL be a registered mux.

Verification (N=8, WIDTH=32)
REQ-038 Reset: hold reset_n=0 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, grant_id=0.
REQ-039 Round-robin: in_valid=0xFF, in_last=0xFF, out_ready=1, manual=0 -> grant_id sequence 0,1,...,7,0, one beat per cycle.
REQ-040 Packet lock: ch2 sends 4 beats (last on 4th), ch5 valid throughout -> 4 ch2 beats contiguous, ch5 granted next cycle.
REQ-041 Backpressure: out_ready=0 for 5 cycles with ch3 beat 0xDEADBEEF held -> out_data stays 0xDEADBEEF, in_ready=0, no beat lost or duplicated after out_ready=1.
REQ-042 Manual: manual=1, sel=6, in_valid=0x41 -> only ch6 served; sel changed to 0 mid-packet ignored until ch6 last accepted.
REQ-043 Reset mid-packet: ch1 in LOCKED, reset_n=0 one cycle -> state IDLE, ptr=0, next grant ch0 if in_valid[0]=1.
